// File: rtl/commit_checker_pkg.sv
// Shared types for the lockstep commit checker: commit record layout,
// failure codes, checker states and the field-priority compare.
package commit_checker_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic [31:0] inst;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
    logic [31:0] mcause;
  } commit_rec_t;

  typedef enum logic [3:0] {
    FC_NONE     = 4'd0,
    FC_PC       = 4'd1,
    FC_DNPC     = 4'd2,
    FC_INST     = 4'd3,
    FC_RF_WEN   = 4'd4,
    FC_RF_WADDR = 4'd5,
    FC_RF_WDATA = 4'd6,
    FC_CSR      = 4'd7,
    FC_TIMEOUT  = 4'd8,
    FC_OVERFLOW = 4'd9
  } fail_code_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FAIL  = 3'd3,
    ST_DONE  = 3'd4
  } chk_state_e;

  // Lowest-numbered differing field wins; register-file write data and address
  // are only meaningful when the reference actually writes a non-zero register.
  function automatic fail_code_e compare_rec(input commit_rec_t dut, input commit_rec_t exp_rec);
    fail_code_e code;
    logic       rf_live;
    rf_live = exp_rec.rf_wen && (exp_rec.rf_waddr != 5'd0);
    code    = FC_NONE;
    if (dut.pc != exp_rec.pc)
      code = FC_PC;
    else if (dut.dnpc != exp_rec.dnpc)
      code = FC_DNPC;
    else if (dut.inst != exp_rec.inst)
      code = FC_INST;
    else if (dut.rf_wen != exp_rec.rf_wen)
      code = FC_RF_WEN;
    else if (rf_live && (dut.rf_waddr != exp_rec.rf_waddr))
      code = FC_RF_WADDR;
    else if (rf_live && (dut.rf_wdata != exp_rec.rf_wdata))
      code = FC_RF_WDATA;
    else if ({dut.mtvec, dut.mepc, dut.mstatus, dut.mcause} !=
             {exp_rec.mtvec, exp_rec.mepc, exp_rec.mstatus, exp_rec.mcause})
      code = FC_CSR;
    return code;
  endfunction

endpackage

// File: rtl/commit_checker_fifo.sv
// Synchronous FIFO of commit records; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module commit_checker_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (!do_push && do_pop)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/commit_checker.sv
// Lockstep commit checker: buffers DUT retire records and compares each one
// against a reference record, latching the first divergence.
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        halt,
  input  logic        cmt_valid,
  input  commit_rec_t cmt_rec,
  input  logic        ref_valid,
  input  commit_rec_t ref_rec,
  output logic        ref_ready,
  output logic        done,
  output logic        fail,
  output logic [3:0]  fail_code,
  output logic [31:0] fail_pc,
  output logic [31:0] commit_cnt,
  output logic [2:0]  dbg_state
);

  chk_state_e  state;
  chk_state_e  state_nxt;
  fail_code_e  fail_code_q;
  fail_code_e  cmp_code;
  fail_code_e  err_code;
  logic [31:0] err_pc;
  logic [31:0] wdog;
  commit_rec_t head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        overflow;
  logic        timeout_hit;
  logic        active;

  // Reference handshake: a record transfers on a cycle where ref_valid and
  // ref_ready are both high; ref_ready depends only on checker state and FIFO
  // occupancy, never on ref_valid, so the producer may wait on it freely.
  assign active    = (state == ST_RUN) || (state == ST_DRAIN);
  assign ref_ready = active && !empty;
  assign pop       = ref_valid && ref_ready;
  assign push      = cmt_valid && (state == ST_RUN);
  assign overflow  = push && full && !pop;
  assign timeout_hit = (TIMEOUT != 0) && (state == ST_RUN) && !push &&
                       (wdog == 32'(TIMEOUT - 1));
  assign cmp_code  = pop ? compare_rec(head, ref_rec) : FC_NONE;

  commit_checker_fifo #(
    .T     (commit_rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (cmt_rec),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // A record mismatch outranks overflow, which outranks the watchdog.
  always_comb begin
    err_code = FC_NONE;
    err_pc   = '0;
    if (cmp_code != FC_NONE) begin
      err_code = cmp_code;
      err_pc   = head.pc;
    end else if (overflow) begin
      err_code = FC_OVERFLOW;
      err_pc   = cmt_rec.pc;
    end else if (timeout_hit) begin
      err_code = FC_TIMEOUT;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN: begin
        if (err_code != FC_NONE) state_nxt = ST_FAIL;
        else if (halt)           state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (err_code != FC_NONE)  state_nxt = ST_FAIL;
        else if (empty && !push)  state_nxt = ST_DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      fail_code_q <= FC_NONE;
      fail_pc     <= '0;
      commit_cnt  <= '0;
      wdog        <= '0;
    end else begin
      state <= state_nxt;
      if (err_code != FC_NONE) begin
        fail_code_q <= err_code;
        fail_pc     <= err_pc;
      end
      if (pop && (cmp_code == FC_NONE))
        commit_cnt <= commit_cnt + 32'd1;
      if (state == ST_RUN)
        wdog <= push ? 32'd0 : wdog + 32'd1;
    end
  end

  assign done      = (state == ST_DONE);
  assign fail      = (state == ST_FAIL);
  assign fail_code = fail_code_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_commit_checker.sv
// Randomized and directed bench for commit_checker against a queue-based
// behavioural model of the checking rules.
module tb_commit_checker;
  import commit_checker_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_FAIL = 3, PH_DONE = 4;

  logic        clk = 1'b0;
  logic        reset, enable, halt, cmt_valid, ref_valid;
  commit_rec_t cmt_rec, ref_rec;
  logic        ref_ready, done, fail;
  logic [3:0]  fail_code;
  logic [31:0] fail_pc, commit_cnt;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  commit_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .halt(halt),
    .cmt_valid(cmt_valid), .cmt_rec(cmt_rec),
    .ref_valid(ref_valid), .ref_rec(ref_rec), .ref_ready(ref_ready),
    .done(done), .fail(fail), .fail_code(fail_code), .fail_pc(fail_pc),
    .commit_cnt(commit_cnt), .dbg_state(dbg_state)
  );

  // ---------------- behavioural model ----------------
  commit_rec_t exp_q[$];
  commit_rec_t ref_src[$];
  int          m_phase = PH_IDLE;
  int          m_code = 0;
  logic [31:0] m_cnt = 0, m_pc = 0, m_wdog = 0;
  bit          m_popped = 0;
  bit          ref_en = 0;
  bit          check_en = 0;

  function automatic int field_code(commit_rec_t d, commit_rec_t r);
    bit [7:0] diff;
    bit       live;
    live    = r.rf_wen && (r.rf_waddr != 0);
    diff    = '0;
    diff[1] = d.pc != r.pc;
    diff[2] = d.dnpc != r.dnpc;
    diff[3] = d.inst != r.inst;
    diff[4] = d.rf_wen != r.rf_wen;
    diff[5] = live && (d.rf_waddr != r.rf_waddr);
    diff[6] = live && (d.rf_wdata != r.rf_wdata);
    diff[7] = (d.mtvec != r.mtvec) || (d.mepc != r.mepc) ||
              (d.mstatus != r.mstatus) || (d.mcause != r.mcause);
    for (int k = 1; k < 8; k++) if (diff[k]) return k;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit          active, pop, push, was_empty;
    int          code;
    logic [31:0] pc;
    active   = (m_phase == PH_RUN) || (m_phase == PH_DRAIN);
    pop      = active && (exp_q.size() > 0) && ref_valid;
    push     = (m_phase == PH_RUN) && cmt_valid;
    m_popped = pop && !reset;
    if (reset) begin
      exp_q.delete();
      m_phase = PH_IDLE; m_code = 0; m_pc = 0; m_cnt = 0; m_wdog = 0;
    end else begin
      code = 0; pc = 0;
      if (pop) begin
        code = field_code(exp_q[0], ref_rec);
        pc   = exp_q[0].pc;
        if (code == 0) m_cnt = m_cnt + 1;
      end
      if (code == 0 && push && exp_q.size() == DEPTH && !pop) begin
        code = 9; pc = cmt_rec.pc;
      end
      if (code == 0 && m_phase == PH_RUN && !push && m_wdog == TIMEOUT - 1) begin
        code = 8; pc = 0;
      end
      if (m_phase == PH_RUN) m_wdog = push ? 0 : m_wdog + 1;
      was_empty = (exp_q.size() == 0);
      if (pop) void'(exp_q.pop_front());
      if (push && exp_q.size() < DEPTH) exp_q.push_back(cmt_rec);
      if (code != 0) begin
        m_phase = PH_FAIL; m_code = code; m_pc = pc;
      end else if (m_phase == PH_IDLE && enable)
        m_phase = PH_RUN;
      else if (m_phase == PH_RUN && halt)
        m_phase = PH_DRAIN;
      else if (m_phase == PH_DRAIN && was_empty)
        m_phase = PH_DONE;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      chk("ref_ready", 80'(ref_ready),
          80'(((m_phase == PH_RUN) || (m_phase == PH_DRAIN)) && exp_q.size() > 0));
      chk("done", 80'(done), 80'(m_phase == PH_DONE));
      chk("fail", 80'(fail), 80'(m_phase == PH_FAIL));
      chk("fail_code", 80'(fail_code), 80'(m_code));
      chk("fail_pc", 80'(fail_pc), 80'(m_pc));
      chk("commit_cnt", 80'(commit_cnt), 80'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    ref_valid = ref_en && (ref_src.size() > 0);
    ref_rec   = (ref_src.size() > 0) ? ref_src[0] : '0;
    @(posedge clk);
    @(negedge clk);
    if (m_popped) void'(ref_src.pop_front());
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; halt = 0; cmt_valid = 0; cmt_rec = '0;
    ref_en = 0; ref_src.delete();
    run(2);
    reset = 0;
  endtask

  task automatic start();
    do_reset();
    enable = 1; tick(); enable = 0;
  endtask

  task automatic commit(commit_rec_t d, commit_rec_t r, bit hlt);
    cmt_valid = 1; cmt_rec = d; halt = hlt;
    ref_src.push_back(r);
    tick();
    cmt_valid = 0; halt = 0;
  endtask

  function automatic commit_rec_t mk_rec(int i);
    commit_rec_t r;
    r.pc       = 32'h8000_0000 + 32'(4 * i);
    r.dnpc     = r.pc + 32'd4;
    r.inst     = $urandom;
    r.rf_wen   = 1'($urandom_range(0, 1));
    r.rf_waddr = 5'($urandom_range(0, 31));
    r.rf_wdata = $urandom;
    r.mtvec    = $urandom;
    r.mepc     = $urandom;
    r.mstatus  = $urandom;
    r.mcause   = $urandom;
    return r;
  endfunction

  function automatic commit_rec_t corrupt(commit_rec_t r, int sel);
    case (sel)
      0: r.pc       = r.pc ^ 32'h10;
      1: r.dnpc     = r.dnpc ^ 32'h4;
      2: r.inst     = r.inst ^ 32'h1;
      3: r.rf_wen   = ~r.rf_wen;
      4: r.rf_waddr = r.rf_waddr ^ 5'h1;
      5: r.rf_wdata = r.rf_wdata ^ 32'h80;
      6: r.mcause   = r.mcause ^ 32'h2;
      default: r.mtvec = r.mtvec ^ 32'h100;
    endcase
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    commit_rec_t d, r;
    int cprob, rprob;

    do_reset();
    check_en = 1;
    chk("reset_state", {ref_ready, done, fail, fail_code, fail_pc, commit_cnt}, '0);

    // ten identical records
    start();
    ref_en = 1;
    for (int i = 0; i < 10; i++) begin
      d = mk_rec(i);
      commit(d, d, 0);
    end
    run(4);
    chk("match_cnt", 80'(commit_cnt), 80'd10);
    chk("match_fail", 80'(fail), 80'd0);

    // rf_wdata divergence on the third record
    start();
    ref_en = 1;
    for (int i = 0; i < 5; i++) begin
      d = mk_rec(i); r = d;
      if (i == 2) begin
        d.rf_wen = 1; d.rf_waddr = 5'd5; d.rf_wdata = 32'h1235;
        r = d; r.rf_wdata = 32'h1234;
      end
      commit(d, r, 0);
    end
    run(4);
    chk("wdata_code", 80'(fail_code), 80'd6);
    chk("wdata_pc", 80'(fail_pc), 80'h8000_0008);
    chk("wdata_cnt", 80'(commit_cnt), 80'd2);

    // x0 write data ignored, then pc and inst both differ
    start();
    ref_en = 1;
    d = mk_rec(0); d.rf_wen = 1; d.rf_waddr = 5'd0;
    r = d; r.rf_wdata = d.rf_wdata ^ 32'hff;
    commit(d, r, 0);
    d = mk_rec(1);
    r = d; r.pc = d.pc ^ 32'h10; r.inst = d.inst ^ 32'h1;
    commit(d, r, 0);
    run(4);
    chk("pc_code", 80'(fail_code), 80'd1);
    chk("pc_fail_pc", 80'(fail_pc), 80'h8000_0004);
    chk("x0_cnt", 80'(commit_cnt), 80'd1);

    // overflow on the fifth push with no reference traffic
    start();
    for (int i = 0; i < 5; i++) begin
      d = mk_rec(i); commit(d, d, 0);
    end
    chk("ovf_fail", 80'(fail), 80'd1);
    chk("ovf_code", 80'(fail_code), 80'd9);
    chk("ovf_pc", 80'(fail_pc), 80'h8000_0010);

    // full FIFO with a pop on the fifth push is accepted
    start();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ref_en = 1;
      d = mk_rec(i); commit(d, d, 0);
    end
    run(6);
    chk("fullpop_fail", 80'(fail), 80'd0);
    chk("fullpop_cnt", 80'(commit_cnt), 80'd5);

    // watchdog
    start();
    run(TIMEOUT - 1);
    chk("wdog_early", 80'(fail), 80'd0);
    tick();
    chk("wdog_fail", 80'(fail), 80'd1);
    chk("wdog_code", 80'(fail_code), 80'd8);
    chk("wdog_pc", 80'(fail_pc), 80'd0);

    // halt with three queued records, then drain
    start();
    for (int i = 0; i < 3; i++) begin
      d = mk_rec(i); commit(d, d, i == 2);
    end
    ref_en = 1;
    run(3);
    chk("drain_notyet", 80'(done), 80'd0);
    tick();
    chk("drain_done", 80'(done), 80'd1);
    chk("drain_cnt", 80'(commit_cnt), 80'd3);

    // reset in the middle of a run
    start();
    ref_en = 1;
    for (int i = 0; i < 3; i++) begin
      d = mk_rec(i); commit(d, d, 0);
    end
    reset = 1; ref_src.delete(); tick();
    chk("midreset", {ref_ready, done, fail, fail_code, fail_pc, commit_cnt}, '0);
    reset = 0;

    // random episodes
    for (int ep = 0; ep < 4; ep++) begin
      start();
      cprob = 50 + ep * 15;
      rprob = 90 - ep * 15;
      for (int c = 0; c < 300; c++) begin
        d = mk_rec(c); r = d;
        if ($urandom_range(0, 39) == 0) r = corrupt(r, int'($urandom_range(0, 7)));
        cmt_valid = ($urandom_range(0, 99) < cprob);
        cmt_rec   = d;
        if (cmt_valid && m_phase == PH_RUN) ref_src.push_back(r);
        ref_en = ($urandom_range(0, 99) < rprob);
        halt   = (c > 200) && ($urandom_range(0, 19) == 0);
        tick();
      end
      cmt_valid = 0; halt = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
